// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Round-robin arbiter and sequencer that shares one 2**ADDR_W x 1-bit
//   register file among NREQ requesters. Each granted request becomes one
//   registered write or read access lasting a single ACCESS cycle. Read data
//   is returned in the following cycle with a one-cycle rvalid pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-high reset (shared with register file)
//   req        in   per-requester request, held until gnt is seen
//   we         in   per-requester op: 1 = write, 0 = read
//   addr       in   per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      in   per-requester write bit
//   gnt        out  one-hot grant, high for the single ACCESS cycle
//   rvalid     out  read data valid, one-cycle pulse
//   rid        out  one-hot owner of rdata (zero when rvalid is low)
//   rdata      out  read data bit (holds last read value)
//   rf_enable  out  register-file write enable
//   rf_wsel    out  register-file write select
//   rf_d       out  register-file write data
//   rf_rsel    out  register-file read select
//   rf_q       in   register-file read data, combinational from rf_rsel
module rf_access_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ-1:0]          wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     rvalid,
  output logic [NREQ-1:0]          rid,
  output logic                     rdata,
  output logic                     rf_enable,
  output logic [ADDR_W-1:0]        rf_wsel,
  output logic                     rf_d,
  output logic [ADDR_W-1:0]        rf_rsel,
  input  logic                     rf_q
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [PTR_W-1:0]    r_ptr,       w_ptr_nxt;
  logic [NREQ-1:0]     r_gnt,       w_gnt_nxt;
  logic                r_rvalid,    w_rvalid_nxt;
  logic [NREQ-1:0]     r_rid,       w_rid_nxt;
  logic                r_rdata,     w_rdata_nxt;
  logic                r_rf_enable, w_rf_enable_nxt;
  logic [ADDR_W-1:0]   r_rf_wsel,   w_rf_wsel_nxt;
  logic                r_rf_d,      w_rf_d_nxt;
  logic [ADDR_W-1:0]   r_rf_rsel,   w_rf_rsel_nxt;

  logic                w_found;
  logic [PTR_W-1:0]    w_win;

  // Round-robin search: the first requester at or after r_ptr, wrapping at
  // NREQ (not at 2**PTR_W) so non-power-of-two counts never see a ghost slot.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(idx);
      end
    end
  end

  // Next-state and next-output logic. The latched op lives in the rf_*
  // registers themselves: during ACCESS, rf_enable is the latched we.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = '0;
    w_rvalid_nxt    = 1'b0;
    w_rid_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_rf_enable_nxt = 1'b0;
    w_rf_wsel_nxt   = '0;
    w_rf_d_nxt      = 1'b0;
    w_rf_rsel_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_ACCESS;
          w_ptr_nxt       = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
          w_gnt_nxt       = NREQ'(1) << w_win;
          w_rf_enable_nxt = we[w_win];
          w_rf_wsel_nxt   = addr[w_win*ADDR_W +: ADDR_W];
          w_rf_rsel_nxt   = addr[w_win*ADDR_W +: ADDR_W];
          w_rf_d_nxt      = wdata[w_win];
        end
      end
      ST_ACCESS: begin
        // The register file commits a write on this same edge; a read is
        // captured from rf_q and reported to the owner of the grant.
        w_state_nxt = ST_IDLE;
        if (!r_rf_enable) begin
          w_rvalid_nxt = 1'b1;
          w_rid_nxt    = r_gnt;
          w_rdata_nxt  = rf_q;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= 1'b0;
      r_rf_enable <= 1'b0;
      r_rf_wsel   <= '0;
      r_rf_d      <= 1'b0;
      r_rf_rsel   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rid       <= w_rid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rf_enable <= w_rf_enable_nxt;
      r_rf_wsel   <= w_rf_wsel_nxt;
      r_rf_d      <= w_rf_d_nxt;
      r_rf_rsel   <= w_rf_rsel_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rid       = r_rid;
  assign rdata     = r_rdata;
  assign rf_enable = r_rf_enable;
  assign rf_wsel   = r_rf_wsel;
  assign rf_d      = r_rf_d;
  assign rf_rsel   = r_rf_rsel;

endmodule
